cache_sa_wb_ctrl: RTL and testbench
===================================

Name: cache_sa_wb_ctrl

Overview:
- Parametrised N-way set-associative write-back, write-allocate data cache with true-LRU replacement.
- Sits between the CPU datapath and main memory, using a valid/ready handshake on the CPU side and a req/ack handshake on the memory side.
- Unlike the earlier single-cycle cache, it allocates on write miss, stalls for multi-cycle memory, and exposes hit/miss counters.

Parameters:
- DATA_W, 8, word width in bits; one word per line, no offset.
- INDEX_W, 2, set index bits; SETS = 2**INDEX_W.
- TAG_W, 3, tag bits; address width is TAG_W+INDEX_W.
- WAYS, 2, associativity; legal values are 2 and 4.
- CNT_W, 16, width of the performance counters.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  request valid; sampled only in IDLE
- cpu_wren  in  1  1=write, 0=read
- cpu_addr  in  TAG_W+INDEX_W  {tag,index}
- cpu_wdata  in  DATA_W  write data
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid while cpu_ready=1
- cpu_hit  out  1  1 if the completed access hit, valid while cpu_ready=1
- mem_req  out  1  memory request, held until mem_ack
- mem_wren  out  1  1=writeback, 0=fill
- mem_addr  out  TAG_W+INDEX_W  memory word address
- mem_wdata  out  DATA_W  writeback data
- mem_rdata  in  DATA_W  fill data, valid with mem_ack
- mem_ack  in  1  completion; ignored when mem_req=0
- hit_cnt  out  CNT_W  saturating count of hits
- miss_cnt  out  CNT_W  saturating count of misses

Behaviour:
- Line state: valid, dirty, tag[TAG_W], data[DATA_W], age[log2 WAYS]. Age 0 = MRU; age WAYS-1 = LRU.
- Reset:
  - All lines: valid=0, dirty=0; age of way w = w.
  - All outputs and counters = 0; FSM = IDLE.
  - A reset asserted mid-transaction aborts it. mem_req drops at that edge, and no line or counter is modified by the aborted access.
- FSM states: IDLE, LOOKUP, WB, FILL, DONE.
  - IDLE: if cpu_req=1, latch wren/addr/wdata and go to LOOKUP; otherwise stay. cpu_req outside IDLE is ignored, with no queueing.
  - LOOKUP, hit (valid and tag match, at most one way):
    - read returns line data; write stores wdata and sets dirty=1;
    - age update; hit_cnt++; cpu_hit=1; go to DONE.
  - LOOKUP, miss:
    - miss_cnt++; victim = lowest-index invalid way, else the way with age WAYS-1;
    - go to WB if the victim is valid and dirty, else to FILL.
  - WB: mem_req=1, mem_wren=1, mem_addr={victim tag,index}, mem_wdata=victim data. On mem_ack, clear victim dirty and go to FILL.
  - FILL: mem_req=1, mem_wren=0, mem_addr=latched addr. On mem_ack, install the line: valid=1, tag=latched tag, data=mem_rdata, dirty=0.
    - For a write, data=wdata and dirty=1 instead (write-allocate).
    - Age update; cpu_hit=0; go to DONE.
  - DONE: cpu_ready=1 for exactly this cycle, with cpu_rdata held (written data for writes). Return to IDLE.
- Latency:
  - Hit: cpu_ready is asserted 2 cycles after the cpu_req sample edge.
  - Miss: 2 + ack waits in FILL (+ ack waits in WB).
  - mem_ack in the same cycle mem_req first rises is accepted; the minimum is 1 cycle per memory phase.
- Age update on access to way k with old age a: ways with age < a increment, way k becomes 0, and ages >= a are unchanged. Ages stay a permutation of 0..WAYS-1 at all times.
- mem_req/mem_wren/mem_addr/mem_wdata are stable from assertion until the cycle after mem_ack. mem_req=0 in IDLE/LOOKUP/DONE.
- Counters saturate at 2**CNT_W-1 with no wrap.
- Addresses wrap naturally; no bounds checks are needed.

Test Plan:
- After reset, read addr 5'b00101 with mem returning 8'hA5 after 3 cycles → WB skipped, FILL mem_addr=5'b00101, cpu_ready at sample+5, cpu_rdata=A5, cpu_hit=0, miss_cnt=1.
- Repeat the same read → cpu_ready exactly 2 cycles after sample, cpu_rdata=A5, cpu_hit=1, no mem_req, hit_cnt=1.
- Write 8'h3C to 5'b00101 (hit), then read 5'b01001 and 5'b01101 (same set, WAYS=2) → the second miss evicts dirty tag 001: WB mem_addr=5'b00101, mem_wdata=3C, then FILL 5'b01101.
- LRU: read A=5'b00010 and B=5'b00110, reread A, then read C=5'b01010 → B is evicted; a later read of A hits, and a read of B misses.
- Reset asserted while in FILL awaiting ack → next cycle mem_req=0, state IDLE, all valid=0, counters 0; a stray mem_ack afterwards has no effect.
- cpu_req held high during a miss → only one access is performed; pulses during WB/FILL are ignored; hit_cnt+miss_cnt equals accepted requests.

Source files
------------

// File: rtl/cache_sa_wb_ctrl.sv
// N-way set-associative write-back / write-allocate data cache controller with true-LRU ageing.
// Latency: a hit completes 2 cycles after the request is sampled; a miss adds one or more cycles per memory phase (WB, FILL).
// Backpressure: one access in flight; cpu_req is only sampled in IDLE; each memory phase holds mem_req until mem_ack.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   cpu_req/wren/addr/wdata CPU request, addr = {tag, index}
//   cpu_ready/rdata/hit     one-cycle completion pulse with read data and hit flag
//   mem_req/wren/addr/wdata memory request (wren=1 writeback, 0 fill), held until mem_ack
//   mem_rdata/mem_ack       fill data and completion from memory
//   hit_cnt/miss_cnt        saturating performance counters
module cache_sa_wb_ctrl #(
    parameter int DATA_W  = 8,
    parameter int INDEX_W = 2,
    parameter int TAG_W   = 3,
    parameter int WAYS    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cpu_req,
    input  logic                     cpu_wren,
    input  logic [TAG_W+INDEX_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0]        cpu_wdata,
    output logic                     cpu_ready,
    output logic [DATA_W-1:0]        cpu_rdata,
    output logic                     cpu_hit,
    output logic                     mem_req,
    output logic                     mem_wren,
    output logic [TAG_W+INDEX_W-1:0] mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_ack,
    output logic [CNT_W-1:0]         hit_cnt,
    output logic [CNT_W-1:0]         miss_cnt
);

    localparam int SETS  = 2**INDEX_W;
    localparam int AGE_W = $clog2(WAYS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        WB     = 3'd2,
        FILL   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    // Line storage
    logic              valid_mem [SETS][WAYS];
    logic              dirty_mem [SETS][WAYS];
    logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
    logic [DATA_W-1:0] data_mem  [SETS][WAYS];
    logic [AGE_W-1:0]  age_mem   [SETS][WAYS];

    // Latched request and per-access context
    logic               wren_q;
    logic [TAG_W-1:0]   tag_q;
    logic [INDEX_W-1:0] idx_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [AGE_W-1:0]   victim_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               hit_q;

    // Lookup results for the latched set
    logic               hit;
    logic [AGE_W-1:0]   hit_way;
    logic               inv_found;
    logic [AGE_W-1:0]   victim_way;
    logic [AGE_W-1:0]   acc_way;
    logic [AGE_W-1:0]   acc_age;
    logic [AGE_W-1:0]   age_nxt [WAYS];

    // Tag compare: at most one way can match, so the last match wins without conflict.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_mem[idx_q][w] && (tag_mem[idx_q][w] == tag_q)) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
        end
    end

    // Victim choice: lowest-index invalid way first (descending scan so the
    // lowest index is written last), otherwise the LRU way.
    always_comb begin
        inv_found  = 1'b0;
        victim_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_mem[idx_q][w]) begin
                inv_found  = 1'b1;
                victim_way = AGE_W'(w);
            end
        end
        if (!inv_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_mem[idx_q][w] == AGE_W'(WAYS - 1)) begin
                    victim_way = AGE_W'(w);
                end
            end
        end
    end

    // Ageing for the way being touched: younger ways slide one step older,
    // the touched way becomes MRU, older ways keep their age. This keeps the
    // ages of a set a permutation of 0..WAYS-1.
    always_comb begin
        acc_way = (state == FILL) ? victim_q : hit_way;
        acc_age = age_mem[idx_q][acc_way];
        for (int w = 0; w < WAYS; w++) begin
            if (AGE_W'(w) == acc_way) begin
                age_nxt[w] = '0;
            end else if (age_mem[idx_q][w] < acc_age) begin
                age_nxt[w] = age_mem[idx_q][w] + 1'b1;
            end else begin
                age_nxt[w] = age_mem[idx_q][w];
            end
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cpu_req) begin
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    state_nxt = DONE;
                end else if (valid_mem[idx_q][victim_way] && dirty_mem[idx_q][victim_way]) begin
                    state_nxt = WB;
                end else begin
                    state_nxt = FILL;
                end
            end
            WB: begin
                if (mem_ack) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (mem_ack) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are decoded from state; the victim line is not touched during
    // WB until the ack edge, so the writeback address and data stay stable.
    always_comb begin
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        cpu_hit   = 1'b0;
        mem_req   = 1'b0;
        mem_wren  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state)
            WB: begin
                mem_req   = 1'b1;
                mem_wren  = 1'b1;
                mem_addr  = {tag_mem[idx_q][victim_q], idx_q};
                mem_wdata = data_mem[idx_q][victim_q];
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = {tag_q, idx_q};
            end
            DONE: begin
                cpu_ready = 1'b1;
                cpu_rdata = rdata_q;
                cpu_hit   = hit_q;
            end
            default: begin
            end
        endcase
    end

    // Datapath: request latch, line updates, counters
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_mem[s][w] <= 1'b0;
                    dirty_mem[s][w] <= 1'b0;
                    tag_mem[s][w]   <= '0;
                    data_mem[s][w]  <= '0;
                    age_mem[s][w]   <= AGE_W'(w);
                end
            end
            wren_q   <= 1'b0;
            tag_q    <= '0;
            idx_q    <= '0;
            wdata_q  <= '0;
            victim_q <= '0;
            rdata_q  <= '0;
            hit_q    <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cpu_req) begin
                        wren_q  <= cpu_wren;
                        tag_q   <= cpu_addr[TAG_W+INDEX_W-1:INDEX_W];
                        idx_q   <= cpu_addr[INDEX_W-1:0];
                        wdata_q <= cpu_wdata;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        hit_q <= 1'b1;
                        if (hit_cnt != '1) begin
                            hit_cnt <= hit_cnt + 1'b1;
                        end
                        if (wren_q) begin
                            data_mem[idx_q][hit_way]  <= wdata_q;
                            dirty_mem[idx_q][hit_way] <= 1'b1;
                            rdata_q                   <= wdata_q;
                        end else begin
                            rdata_q <= data_mem[idx_q][hit_way];
                        end
                        for (int w = 0; w < WAYS; w++) begin
                            age_mem[idx_q][w] <= age_nxt[w];
                        end
                    end else begin
                        hit_q    <= 1'b0;
                        victim_q <= victim_way;
                        if (miss_cnt != '1) begin
                            miss_cnt <= miss_cnt + 1'b1;
                        end
                    end
                end
                WB: begin
                    if (mem_ack) begin
                        dirty_mem[idx_q][victim_q] <= 1'b0;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        valid_mem[idx_q][victim_q] <= 1'b1;
                        tag_mem[idx_q][victim_q]   <= tag_q;
                        // Write-allocate: the fill is immediately overwritten by the store.
                        if (wren_q) begin
                            data_mem[idx_q][victim_q]  <= wdata_q;
                            dirty_mem[idx_q][victim_q] <= 1'b1;
                            rdata_q                    <= wdata_q;
                        end else begin
                            data_mem[idx_q][victim_q]  <= mem_rdata;
                            dirty_mem[idx_q][victim_q] <= 1'b0;
                            rdata_q                    <= mem_rdata;
                        end
                        for (int w = 0; w < WAYS; w++) begin
                            age_mem[idx_q][w] <= age_nxt[w];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_sa_wb_ctrl.sv
// Self-checking bench for cache_sa_wb_ctrl.
// Reference model keeps per-line valid/dirty/tag/data plus a last-use timestamp per way (LRU = oldest stamp).
// A behavioural memory answers WB/FILL phases after a chosen number of cycles.
module tb_cache_sa_wb_ctrl;

    localparam int DATA_W  = 8;
    localparam int INDEX_W = 2;
    localparam int TAG_W   = 3;
    localparam int WAYS    = 2;
    localparam int CNT_W   = 16;
    localparam int SETS    = 4;
    localparam int ADDR_W  = 5;

    logic              clock = 1'b0;
    logic              reset;
    logic              cpu_req;
    logic              cpu_wren;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_hit;
    logic              mem_req;
    logic              mem_wren;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    always #5 clock = ~clock;

    cache_sa_wb_ctrl #(
        .DATA_W (DATA_W),
        .INDEX_W(INDEX_W),
        .TAG_W  (TAG_W),
        .WAYS   (WAYS),
        .CNT_W  (CNT_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .cpu_req  (cpu_req),
        .cpu_wren (cpu_wren),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready),
        .cpu_rdata(cpu_rdata),
        .cpu_hit  (cpu_hit),
        .mem_req  (mem_req),
        .mem_wren (mem_wren),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model
    logic              m_valid [SETS][WAYS];
    logic              m_dirty [SETS][WAYS];
    logic [TAG_W-1:0]  m_tag   [SETS][WAYS];
    logic [DATA_W-1:0] m_data  [SETS][WAYS];
    int                m_stamp [SETS][WAYS];
    int                m_tick;
    int                m_hits;
    int                m_misses;
    int                n_acc;
    logic [DATA_W-1:0] bmem [2**ADDR_W];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_tag[s][w]   = '0;
                m_data[s][w]  = '0;
                m_stamp[s][w] = -w;   // way 0 is MRU after reset, way WAYS-1 is LRU
            end
        end
        m_tick   = 1;
        m_hits   = 0;
        m_misses = 0;
        n_acc    = 0;
    endtask

    // mode 0: pulse cpu_req for the sample edge only
    // mode 1: hold cpu_req high until completion
    // mode 2: random cpu_req / address / data noise while busy
    task automatic do_access(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                             input int fill_d, input int wb_d, input int mode);
        logic [INDEX_W-1:0] si;
        logic [TAG_W-1:0]   tg;
        logic               exp_hit;
        logic               wb_exp;
        logic [ADDR_W-1:0]  wb_addr;
        logic [DATA_W-1:0]  wb_data;
        logic [DATA_W-1:0]  exp_rd;
        int                 exp_lat;
        int                 way;
        int                 c;
        logic               done;
        int                 wb_seen;
        int                 fill_seen;
        int                 ph_cnt;
        logic [ADDR_W+DATA_W:0] ph_sig;

        si      = addr[INDEX_W-1:0];
        tg      = addr[ADDR_W-1:INDEX_W];
        exp_hit = 1'b0;
        way     = 0;
        wb_exp  = 1'b0;
        wb_addr = '0;
        wb_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[si][w] && m_tag[si][w] == tg) begin
                exp_hit = 1'b1;
                way     = w;
            end
        end
        if (exp_hit) begin
            m_hits++;
            if (wr) begin
                m_data[si][way]  = wd;
                m_dirty[si][way] = 1'b1;
            end
            exp_rd  = m_data[si][way];
            exp_lat = 2;
        end else begin
            m_misses++;
            way = -1;
            for (int w = 0; w < WAYS; w++) begin
                if (!m_valid[si][w] && way < 0) way = w;
            end
            if (way < 0) begin
                way = 0;
                for (int w = 1; w < WAYS; w++) begin
                    if (m_stamp[si][w] < m_stamp[si][way]) way = w;
                end
            end
            if (m_valid[si][way] && m_dirty[si][way]) begin
                wb_exp        = 1'b1;
                wb_addr       = {m_tag[si][way], si};
                wb_data       = m_data[si][way];
                bmem[wb_addr] = wb_data;
            end
            m_valid[si][way] = 1'b1;
            m_tag[si][way]   = tg;
            m_dirty[si][way] = wr;
            m_data[si][way]  = wr ? wd : bmem[addr];
            exp_rd  = m_data[si][way];
            exp_lat = 2 + fill_d + (wb_exp ? wb_d : 0);
        end
        m_stamp[si][way] = m_tick;
        m_tick++;
        n_acc++;

        @(posedge clock); #1;
        cpu_req   = 1'b1;
        cpu_wren  = wr;
        cpu_addr  = addr;
        cpu_wdata = wd;
        c         = 0;
        done      = 1'b0;
        wb_seen   = 0;
        fill_seen = 0;
        ph_cnt    = 0;
        ph_sig    = '0;
        while (!done && c < 200) begin
            @(posedge clock); #1;
            c++;
            // memory responder
            if (mem_ack) begin
                mem_ack = 1'b0;
                ph_cnt  = 0;
            end
            mem_rdata = 8'($urandom);
            if (mem_req) begin
                if (ph_cnt == 0) begin
                    ph_sig = {mem_wren, mem_addr, mem_wdata};
                    if (mem_wren) begin
                        wb_seen++;
                        chk("wb_addr", 32'(mem_addr), 32'(wb_addr));
                        chk("wb_data", 32'(mem_wdata), 32'(wb_data));
                    end else begin
                        fill_seen++;
                        chk("fill_addr", 32'(mem_addr), 32'(addr));
                    end
                end else begin
                    chk("mem_stable", 32'({mem_wren, mem_addr, mem_wdata}), 32'(ph_sig));
                end
                ph_cnt++;
                if (ph_cnt >= (mem_wren ? wb_d : fill_d)) begin
                    mem_ack   = 1'b1;
                    mem_rdata = bmem[mem_addr];
                end
            end
            // CPU side
            if (cpu_ready) begin
                done = 1'b1;
                chk("latency", 32'(c), 32'(exp_lat));
                chk("rdata", 32'(cpu_rdata), 32'(exp_rd));
                chk("hit", 32'(cpu_hit), 32'(exp_hit));
                chk("hit_cnt", 32'(hit_cnt), 32'(m_hits));
                chk("miss_cnt", 32'(miss_cnt), 32'(m_misses));
                chk("mem_req_done", 32'(mem_req), 32'(0));
                cpu_req = 1'b0;
            end else begin
                case (mode)
                    0: cpu_req = 1'b0;
                    1: cpu_req = 1'b1;
                    default: begin
                        cpu_req   = 1'($urandom);
                        cpu_wren  = 1'($urandom);
                        cpu_addr  = 5'($urandom);
                        cpu_wdata = 8'($urandom);
                    end
                endcase
            end
        end
        mem_ack = 1'b0;
        cpu_req = 1'b0;
        chk("ready_seen", 32'(done), 32'(1));
        chk("wb_count", 32'(wb_seen), 32'(wb_exp));
        chk("fill_count", 32'(fill_seen), 32'(!exp_hit));
    endtask

    initial begin
        logic in_fill;
        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_wren  = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        for (int a = 0; a < 2**ADDR_W; a++) bmem[a] = 8'($urandom);
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ready", 32'(cpu_ready), 32'(0));
        chk("rst_rdata", 32'(cpu_rdata), 32'(0));
        chk("rst_mem_req", 32'(mem_req), 32'(0));
        chk("rst_hit_cnt", 32'(hit_cnt), 32'(0));
        chk("rst_miss_cnt", 32'(miss_cnt), 32'(0));
        reset = 1'b0;
        model_reset();

        // cold read miss, fill after 3 cycles, then the same read hits
        bmem[5'b00101] = 8'hA5;
        do_access(1'b0, 5'b00101, 8'h00, 3, 1, 0);
        do_access(1'b0, 5'b00101, 8'h00, 1, 1, 0);
        // write hit dirties tag 001; two more misses in set 1 evict it
        do_access(1'b1, 5'b00101, 8'h3C, 1, 1, 0);
        do_access(1'b0, 5'b01001, 8'h00, 2, 1, 0);
        do_access(1'b0, 5'b01101, 8'h00, 1, 2, 0);
        // LRU: A, B, A, C evicts B; A then hits, B misses
        do_access(1'b0, 5'b00010, 8'h00, 1, 1, 0);
        do_access(1'b0, 5'b00110, 8'h00, 1, 1, 0);
        do_access(1'b0, 5'b00010, 8'h00, 1, 1, 0);
        do_access(1'b0, 5'b01010, 8'h00, 2, 1, 0);
        do_access(1'b0, 5'b00010, 8'h00, 1, 1, 0);
        do_access(1'b0, 5'b00110, 8'h00, 1, 1, 0);
        // held request and noisy request lines during misses
        do_access(1'b0, 5'b11111, 8'h00, 3, 2, 1);
        do_access(1'b1, 5'b11011, 8'h77, 2, 3, 2);

        // randomized traffic over a small tag range to mix hits, clean and dirty evictions
        for (int i = 0; i < 200; i++) begin
            do_access(1'($urandom), {3'($urandom_range(0, 3)), 2'($urandom)}, 8'($urandom),
                      $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(0, 2));
        end
        chk("acc_total", 32'(hit_cnt) + 32'(miss_cnt), 32'(n_acc));

        // reset while FILL waits for ack
        @(posedge clock); #1;
        cpu_req  = 1'b1;
        cpu_wren = 1'b0;
        cpu_addr = 5'b11100;
        @(posedge clock); #1;
        cpu_req = 1'b0;
        in_fill = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            mem_ack = 1'b0;
            if (mem_req && !mem_wren) begin
                in_fill = 1'b1;
                break;
            end
            if (mem_req && mem_wren) begin
                bmem[mem_addr] = mem_wdata;
                mem_ack        = 1'b1;
            end
        end
        chk("rst_reach_fill", 32'(in_fill), 32'(1));
        repeat (2) begin
            @(posedge clock); #1;
        end
        chk("fill_held", 32'(mem_req), 32'(1));
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("abort_mem_req", 32'(mem_req), 32'(0));
        chk("abort_ready", 32'(cpu_ready), 32'(0));
        chk("abort_hit_cnt", 32'(hit_cnt), 32'(0));
        chk("abort_miss_cnt", 32'(miss_cnt), 32'(0));
        mem_ack   = 1'b1;
        mem_rdata = 8'hEE;
        @(posedge clock); #1;
        mem_ack = 1'b0;
        chk("stray_ack_mem_req", 32'(mem_req), 32'(0));
        chk("stray_ack_ready", 32'(cpu_ready), 32'(0));
        model_reset();
        // all lines invalid again: previously cached addresses miss
        do_access(1'b0, 5'b00101, 8'h00, 1, 1, 0);
        do_access(1'b0, 5'b11100, 8'h00, 2, 1, 0);
        do_access(1'b0, 5'b00101, 8'h00, 1, 1, 0);
        chk("acc_total_after_rst", 32'(hit_cnt) + 32'(miss_cnt), 32'(n_acc));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
